ir_fetch_sequencer: RTL and testbench

//  Control FSM for the SAYEH fetch/issue path. Drives the memory read handshake,
//  the instruction-register load strobe and PC increment. Splits each 16-bit

---
 rtl/ir_fetch_sequencer_pkg.sv | 22 ++
 rtl/ir_fetch_sequencer_if.sv | 26 ++
 rtl/ir_fetch_sequencer.sv | 102 ++++++++++
 tb/tb_ir_fetch_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ir_fetch_sequencer_pkg.sv
// Shared types for the SAYEH fetch/issue sequencer: FSM state encoding,
// default opcode values and slot-select encodings.
package sayeh_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_ISSUE_HI = 3'd2,
        S_WAIT_HI  = 3'd3,
        S_ISSUE_LO = 3'd4,
        S_WAIT_LO  = 3'd5,
        S_NEXT     = 3'd6,
        S_HALTED   = 3'd7
    } state_e;

    localparam logic [3:0] LONG_OPC_DEF = 4'hF;
    localparam logic [7:0] HALT_OPC_DEF = 8'h01;

    localparam logic SLOT_HI = 1'b0;
    localparam logic SLOT_LO = 1'b1;

endpackage

// File: rtl/ir_fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer (master) and the
// memory / IR / execute environment (slave).
interface ir_fetch_sequencer_if;
    logic        run;
    logic        mem_ack;
    logic [15:0] ir_in;
    logic        exec_done;
    logic        mem_rd;
    logic        ir_load;
    logic        pc_inc;
    logic        exec_start;
    logic        slot_sel;
    logic        long_instr;
    logic        halted;
    logic        busy;

    modport master (
        input  run, mem_ack, ir_in, exec_done,
        output mem_rd, ir_load, pc_inc, exec_start, slot_sel, long_instr, halted, busy
    );

    modport slave (
        output run, mem_ack, ir_in, exec_done,
        input  mem_rd, ir_load, pc_inc, exec_start, slot_sel, long_instr, halted, busy
    );
endinterface

// File: rtl/ir_fetch_sequencer.sv
// SAYEH fetch/issue control FSM: memory read, IR load, slot issue, PC increment.
// Optional build macro SAYEH_SKIP_NOP_EN skips issuing a lower-byte nop (8'h00).
module ir_fetch_sequencer
    import sayeh_pkg::*;
#(
    parameter logic [3:0] LONG_OPC = LONG_OPC_DEF,
    parameter logic [7:0] HALT_OPC = HALT_OPC_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ir_fetch_sequencer_if.master bus
);

    state_e state, state_n;

    logic is_long, hi_halt, lo_halt, skip_lo;
    logic mem_rd, ir_load, pc_inc, exec_start, slot_sel, long_instr, halted, busy;

    assign is_long = (bus.ir_in[15:12] == LONG_OPC);
    assign hi_halt = !is_long && (bus.ir_in[15:8] == HALT_OPC);
    assign lo_halt = (bus.ir_in[7:0] == HALT_OPC);

`ifdef SAYEH_SKIP_NOP_EN
    assign skip_lo = (bus.ir_in[7:0] == 8'h00);
`else
    assign skip_lo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    // Strobes decode from registered state; ir_load alone also needs mem_ack
    // so the IR captures on the negedge of the ack cycle.
    always_comb begin
        state_n    = state;
        mem_rd     = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        exec_start = 1'b0;
        slot_sel   = SLOT_HI;
        long_instr = 1'b0;
        halted     = 1'b0;
        busy       = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.run) state_n = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (bus.mem_ack) begin
                    ir_load = 1'b1;
                    state_n = S_ISSUE_HI;
                end
            end
            S_ISSUE_HI: begin
                exec_start = 1'b1;
                long_instr = is_long;
                state_n    = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                long_instr = is_long;
                if (bus.exec_done) begin
                    if (hi_halt)                state_n = S_HALTED;
                    else if (is_long || skip_lo) state_n = S_NEXT;
                    else                         state_n = S_ISSUE_LO;
                end
            end
            S_ISSUE_LO: begin
                exec_start = 1'b1;
                slot_sel   = SLOT_LO;
                state_n    = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                slot_sel = SLOT_LO;
                if (bus.exec_done) state_n = lo_halt ? S_HALTED : S_NEXT;
            end
            // run is sampled here so a mid-word stop never loses the pc_inc
            S_NEXT: begin
                pc_inc  = 1'b1;
                state_n = bus.run ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
                halted = 1'b1;
                busy   = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.mem_rd     = mem_rd;
    assign bus.ir_load    = ir_load;
    assign bus.pc_inc     = pc_inc;
    assign bus.exec_start = exec_start;
    assign bus.slot_sel   = slot_sel;
    assign bus.long_instr = long_instr;
    assign bus.halted     = halted;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Directed bench for ir_fetch_sequencer: a word-level model expands each
// directed word into its expected per-cycle timeline, compared every cycle.
module tb_ir_fetch_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ir_fetch_sequencer_if bus();
    ir_fetch_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

`ifdef SAYEH_SKIP_NOP_EN
    localparam bit SKIP_NOP = 1'b1;
`else
    localparam bit SKIP_NOP = 1'b0;
`endif

    typedef struct {
        bit          rst, run, ack, done;
        logic [15:0] w;
        bit          mem_rd, ir_load, pc_inc, es, ss, li, hl, bz;
    } cyc_t;

    cyc_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ld_cyc[$];
    int   rd_rise[$];
    int   es_cnt = 0;
    int   pc_cnt = 0;
    bit   prev_rd = 1'b0;

    function automatic cyc_t blank(bit run, logic [15:0] w);
        cyc_t c;
        c     = '{default: 0};
        c.run = run;
        c.w   = w;
        return c;
    endfunction

    function automatic void push_idle(bit run, int n);
        for (int i = 0; i < n; i++) q.push_back(blank(run, 16'h0));
    endfunction

    function automatic void push_rst(bit run);
        cyc_t c;
        c     = blank(run, 16'h0);
        c.rst = 1'b1;
        q.push_back(c);
    endfunction

    function automatic void push_halted(int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c    = blank(1'b1, 16'h0);
            c.hl = 1'b1;
            q.push_back(c);
        end
    endfunction

    // One word's timeline, starting in the first fetch cycle.
    function automatic void add_word(logic [15:0] w, int ack_dly, int done_dly, bit run_after,
                                     bit drop_in_wait_hi, bit done_in_issue, bit abort_lo);
        cyc_t c;
        bit lng, halt_hi, do_lo, halt_lo, r;
        lng     = (w[15:12] == 4'hF);
        halt_hi = !lng && (w[15:8] == 8'h01);
        do_lo   = !lng && !halt_hi && !(SKIP_NOP && w[7:0] == 8'h00);
        halt_lo = do_lo && (w[7:0] == 8'h01);
        r = 1'b1;
        for (int i = 0; i <= ack_dly; i++) begin
            c = blank(1'b1, w); c.mem_rd = 1'b1; c.bz = 1'b1;
            if (i == ack_dly) begin c.ack = 1'b1; c.ir_load = 1'b1; end
            q.push_back(c);
        end
        c = blank(1'b1, w); c.es = 1'b1; c.ss = 1'b0; c.li = lng; c.bz = 1'b1; c.done = done_in_issue;
        q.push_back(c);
        if (drop_in_wait_hi) r = 1'b0;
        for (int j = 0; j <= done_dly; j++) begin
            c = blank(r, w); c.bz = 1'b1; c.done = (j == done_dly);
            q.push_back(c);
        end
        if (halt_hi) return;
        if (do_lo) begin
            c = blank(r, w); c.es = 1'b1; c.ss = 1'b1; c.bz = 1'b1;
            q.push_back(c);
            if (abort_lo) begin
                c = blank(r, w); c.bz = 1'b1;
                q.push_back(c);
                push_rst(1'b1);
                return;
            end
            for (int j = 0; j <= done_dly; j++) begin
                c = blank(r, w); c.bz = 1'b1; c.done = (j == done_dly);
                q.push_back(c);
            end
            if (halt_lo) return;
        end
        c = blank(run_after, w); c.pc_inc = 1'b1; c.bz = 1'b1;
        q.push_back(c);
    endfunction

    task automatic chk(input string nm, input int k, input logic got, input bit exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc%0d got %0b want %0b", nm, k, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic compare(input int k);
        chk("mem_rd",     k, bus.mem_rd,     q[k].mem_rd);
        chk("ir_load",    k, bus.ir_load,    q[k].ir_load);
        chk("pc_inc",     k, bus.pc_inc,     q[k].pc_inc);
        chk("exec_start", k, bus.exec_start, q[k].es);
        chk("halted",     k, bus.halted,     q[k].hl);
        chk("busy",       k, bus.busy,       q[k].bz);
        if (q[k].es) begin
            chk("slot_sel",   k, bus.slot_sel,   q[k].ss);
            chk("long_instr", k, bus.long_instr, q[k].li);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.run       = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.exec_done = 1'b0;
        bus.ir_in     = 16'h0;

        push_rst(1'b0); push_rst(1'b0); push_idle(1'b0, 1); push_idle(1'b1, 1);
        add_word(16'h1234, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_word(16'hF0AB, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_word(16'h3400, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        push_idle(1'b0, 2); push_idle(1'b1, 1);
        add_word(16'h5678, 5, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        push_idle(1'b0, 3); push_idle(1'b1, 1);
        add_word(16'h1201, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_halted(3);
        push_rst(1'b1);
        add_word(16'h9ABC, 0, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        add_word(16'h0122, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_halted(4);

        foreach (q[k]) begin
            @(posedge clk);
            #1;
            if (q[k].rst) reset_n = 1'b0;
            bus.run       = q[k].run;
            bus.mem_ack   = q[k].ack;
            bus.exec_done = q[k].done;
            #3;
            compare(k);
            if (bus.ir_load === 1'b1) ld_cyc.push_back(k);
            if (bus.mem_rd === 1'b1 && !prev_rd) rd_rise.push_back(k);
            prev_rd = (bus.mem_rd === 1'b1);
            if (bus.exec_start === 1'b1) es_cnt++;
            if (bus.pc_inc === 1'b1) pc_cnt++;
            @(negedge clk);
            if (bus.ir_load === 1'b1) bus.ir_in = q[k].w;
            #1;
            reset_n = 1'b1;
        end

        chk_int("exec_start_total", es_cnt, SKIP_NOP ? 11 : 12);
        chk_int("pc_inc_total", pc_cnt, 4);
        chk_int("ir_load_total", ld_cyc.size(), 7);
        chk_int("fetch_total", rd_rise.size(), 7);
        if (ld_cyc.size() >= 4 && rd_rise.size() >= 4) begin
            chk_int("ack_to_next_rd_1234", rd_rise[1] - ld_cyc[0], 6);
            chk_int("mem_rd_hold_5678", ld_cyc[3] - rd_rise[3], 5);
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL event_trace got %0d loads want at least 4", ld_cyc.size());
        end
        chk("halted_final", q.size(), bus.halted, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
